// File: rtl/instr_stream_encoder.sv
// Encodes symbolic MIPS instructions into 32-bit words and streams them into
// instruction RAM at consecutive addresses over a back-pressured write port.
module instr_stream_encoder #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        op_sel,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [15:0]       imm,
  input  logic [25:0]       target,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err_illegal
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {IDLE, WRITE, FULL} state_t;

  typedef struct packed {
    logic [4:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic [25:0] target;
  } req_t;

  state_t      state, state_nxt;
  req_t        req;
  logic [31:0] enc;
  logic        legal;
  logic        accept, commit, flag_illegal;
  logic [ADDR_W:0] count_inc;

  assign req       = '{op_sel, rs, rt, rd, imm, target};
  assign count_inc = count + (ADDR_W+1)'(1);

  always_comb begin
    legal = 1'b1;
    enc   = '0;
    case (req.op)
      5'd0:  enc = {6'h00, req.rs, req.rt, req.rd, 5'd0, 6'h20};
      5'd1:  enc = {6'h00, req.rs, req.rt, req.rd, 5'd0, 6'h22};
      5'd2:  enc = {6'h00, req.rs, req.rt, req.rd, 5'd0, 6'h24};
      5'd3:  enc = {6'h00, req.rs, req.rt, req.rd, 5'd0, 6'h25};
      5'd4:  enc = {6'h00, req.rs, req.rt, req.rd, 5'd0, 6'h2A};
      5'd5:  enc = {6'h23, req.rs, req.rt, req.imm};
      5'd6:  enc = {6'h2B, req.rs, req.rt, req.imm};
      5'd7:  enc = {6'h04, req.rs, req.rt, req.imm};
      5'd8:  enc = {6'h08, req.rs, req.rt, req.imm};
      5'd9:  enc = {6'h02, req.target};
      5'd10: enc = {6'h0C, req.rs, req.rt, req.imm};
      5'd11: enc = {6'h0D, req.rs, req.rt, req.imm};
      5'd12: enc = {6'h0A, req.rs, req.rt, req.imm};
      5'd13: enc = {6'h00, req.rs, req.rt, req.rd, 5'd0, 6'h27};
      5'd14: enc = {6'h00, req.rs, req.rt, req.rd, 5'd0, 6'h26};
      5'd15: enc = {6'h0E, req.rs, req.rt, req.imm};
      5'd16: enc = {6'h05, req.rs, req.rt, req.imm};
      default: legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Handshake outputs decode from state only, so in_ready never sees in_valid.
  always_comb begin
    state_nxt    = state;
    in_ready     = 1'b0;
    mem_we       = 1'b0;
    full         = 1'b0;
    accept       = 1'b0;
    commit       = 1'b0;
    flag_illegal = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (!clear && in_valid) begin
          if (legal) begin
            accept    = 1'b1;
            state_nxt = WRITE;
          end else begin
            flag_illegal = 1'b1;
          end
        end
      end
      WRITE: begin
        mem_we = 1'b1;
        if (!clear && mem_ready) begin
          commit    = 1'b1;
          state_nxt = (count_inc == DEPTH) ? FULL : IDLE;
        end
      end
      FULL:    full = 1'b1;
      default: state_nxt = IDLE;
    endcase
    if (clear) state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_addr    <= '0;
      mem_wdata   <= '0;
      count       <= '0;
      err_illegal <= 1'b0;
    end else if (clear) begin
      mem_addr    <= '0;
      count       <= '0;
      err_illegal <= 1'b0;
    end else begin
      if (accept)       mem_wdata   <= enc;
      // Address wraps to 0 naturally on the final write into the last word.
      if (commit) begin
        mem_addr <= mem_addr + ADDR_W'(1);
        count    <= count_inc;
      end
      if (flag_illegal) err_illegal <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_stream_encoder.sv
// Scoreboard bench: a transaction model predicts writes and status; a monitor
// checks every presented memory write against the expected-write queue.
module tb_instr_stream_encoder;

  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          clear = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [4:0]    op_sel = '0, rs = '0, rt = '0, rd = '0;
  logic [15:0]   imm = '0;
  logic [25:0]   target = '0;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_ready = 1'b0;
  logic [AW:0]   count;
  logic          full;
  logic          err_illegal;

  instr_stream_encoder #(.ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .op_sel(op_sel), .rs(rs), .rt(rt), .rd(rd), .imm(imm), .target(target),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .count(count), .full(full), .err_illegal(err_illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp = 0, n_bad = 0;

  // Opcode 0 marks R-type (funct from the second table); op 9 is the jump.
  logic [5:0] opc_t [0:16] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h23, 6'h2B, 6'h04, 6'h08,
                               6'h02, 6'h0C, 6'h0D, 6'h0A, 6'h00, 6'h00, 6'h0E, 6'h05};
  logic [5:0] fn_t  [0:16] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h00, 6'h00, 6'h00,
                               6'h00, 6'h00, 6'h00, 6'h00, 6'h27, 6'h26, 6'h00, 6'h00};

  bit m_busy, m_full, m_err, m_acc;
  int m_count, m_addr;

  function automatic logic [31:0] ref_enc(int op);
    logic [31:0] w;
    if (op == 9)              w = {opc_t[op], target};
    else if (opc_t[op] == 0)  w = {6'h00, rs, rt, rd, 5'd0, fn_t[op]};
    else                      w = {opc_t[op], rs, rt, imm};
    return w;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_full = 0; m_err = 0; m_acc = 0; m_count = 0; m_addr = 0;
    exp_q.delete();
  endtask

  task automatic model_update();
    wr_t w;
    m_acc = 0;
    if (clear) begin
      m_busy = 0; m_full = 0; m_err = 0; m_count = 0; m_addr = 0;
    end else if (m_busy) begin
      if (mem_ready) begin
        m_busy  = 0;
        m_count = m_count + 1;
        m_addr  = (m_addr + 1) % DEPTH;
        if (m_count == DEPTH) m_full = 1;
      end
    end else if (!m_full && in_valid) begin
      if (int'(op_sel) <= 16) begin
        w.addr = AW'(m_addr);
        w.data = ref_enc(int'(op_sel));
        exp_q.push_back(w);
        m_busy = 1;
        m_acc  = 1;
      end else begin
        m_err = 1;
      end
    end
  endtask

  task automatic check_status();
    chk("in_ready", 32'(in_ready), 32'(!m_busy && !m_full));
    chk("mem_we",   32'(mem_we),   32'(m_busy));
    chk("mem_addr", 32'(mem_addr), 32'(m_addr));
    chk("count",    32'(count),    32'(m_count));
    chk("full",     32'(full),     32'(m_full));
    chk("err",      32'(err_illegal), 32'(m_err));
  endtask

  // One cycle: check state away from the edge, advance model at the edge.
  task automatic tick();
    @(negedge clk);
    check_status();
    @(posedge clk);
    model_update();
    #1;
  endtask

  // Monitor: compares each presented write; completed or aborted writes retire.
  always @(negedge clk) begin
    if (!reset && mem_we) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 32'(mem_addr), 32'hFFFF_FFFF);
      end else begin
        chk("wr_addr", 32'(mem_addr), 32'(exp_q[0].addr));
        chk("wr_data", mem_wdata, exp_q[0].data);
        if (clear || mem_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic set_fields(int op, int a, int b, int c, int im, int tg);
    op_sel = 5'(op); rs = 5'(a); rt = 5'(b); rd = 5'(c); imm = 16'(im); target = 26'(tg);
  endtask

  task automatic send(int op, int a, int b, int c, int im, int tg);
    bit done = 0;
    set_fields(op, a, b, c, im, tg);
    in_valid = 1;
    for (int i = 0; i < 20 && !done; i++) begin
      tick();
      done = m_acc;
    end
    if (!done) chk("send_timeout", 0, 1);
    in_valid = 0;
  endtask

  task automatic do_clear();
    clear = 1; tick(); clear = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    chk("rst_wdata", mem_wdata, 0);

    // ADD rs=1 rt=2 rd=3 -> 0x00221820 @0
    mem_ready = 1;
    send(0, 1, 2, 3, 0, 0);
    chk("add_word", exp_q[0].data, 32'h0022_1820);
    tick(); tick();

    // Back-to-back LW, J, BNE from a clean start
    do_clear();
    send(5, 29, 8, 0, 16'h0004, 0);
    send(9, 0, 0, 0, 0, 26'h0000010);
    send(16, 4, 5, 0, 16'hFFFE, 0);
    tick(); tick();

    // ORI held under back-pressure for four cycles
    mem_ready = 0;
    send(11, 7, 9, 0, 16'h1234, 0);
    repeat (4) tick();
    mem_ready = 1;
    tick(); tick(); tick();

    // Illegal op then SUB at the next address
    do_clear();
    mem_ready = 1;
    send(0, 3, 4, 5, 0, 0);
    tick();
    set_fields(20, 1, 2, 3, 0, 0);
    in_valid = 1; tick(); in_valid = 0;
    tick(); tick();
    send(1, 1, 2, 3, 0, 0);
    tick(); tick();

    // Fill to DEPTH, then the fifth instruction is ignored
    do_clear();
    for (int i = 0; i < DEPTH; i++) send(8, i, i + 1, 0, i * 3, 0);
    tick();
    set_fields(3, 1, 1, 1, 0, 0);
    in_valid = 1; repeat (3) tick(); in_valid = 0;
    do_clear();
    tick();

    // clear in WRITE together with mem_ready aborts the write
    mem_ready = 0;
    send(2, 6, 7, 8, 0, 0);
    clear = 1; mem_ready = 1; tick(); clear = 0;
    tick(); tick();

    // Asynchronous reset in the middle of a write
    mem_ready = 0;
    send(14, 9, 10, 11, 0, 0);
    tick();
    reset = 1;
    #1;
    chk("rst_async_we", 32'(mem_we), 0);
    chk("rst_async_count", 32'(count), 0);
    model_reset();
    @(negedge clk);
    reset = 0;
    @(posedge clk);
    #1;
    tick();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      clear     = ($urandom_range(0, 99) < 3);
      mem_ready = ($urandom_range(0, 99) < 65);
      in_valid  = ($urandom_range(0, 99) < 60);
      set_fields(($urandom_range(0, 9) == 0) ? $urandom_range(17, 31) : $urandom_range(0, 16),
                 $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                 $urandom_range(0, 65535), $urandom_range(0, (1 << 26) - 1));
      tick();
    end
    in_valid = 0;
    clear = 0;
    do_clear();
    tick();
    chk("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
